// File: rtl/lcd_pkg.sv
// Shared constants, FSM encoding and helpers for the hex LCD writer.
package lcd_pkg;

  // HD44780 commands used by the writer
  localparam logic [7:0] CMD_FUNC  = 8'h38;  // 8-bit bus, 2 lines, 5x8 font
  localparam logic [7:0] CMD_DISP  = 8'h0C;  // display on, cursor off
  localparam logic [7:0] CMD_ENTRY = 8'h06;  // increment, no shift
  localparam logic [7:0] CMD_CLEAR = 8'h01;  // clear display (long execution)
  localparam logic [7:0] CMD_LINE1 = 8'h80;  // DDRAM address 0, line 1

  // Sequencer states
  // state    | meaning
  // PWRUP    | waiting for LCD power-up after reset
  // INIT     | sending the four init commands
  // IDLE     | waiting for a new value or refresh
  // ADDR     | sending the line-1 address command
  // CHARS    | sending the eight hex characters
  localparam logic [2:0] ST_PWRUP = 3'd0;
  localparam logic [2:0] ST_INIT  = 3'd1;
  localparam logic [2:0] ST_IDLE  = 3'd2;
  localparam logic [2:0] ST_ADDR  = 3'd3;
  localparam logic [2:0] ST_CHARS = 3'd4;

  // Uppercase hex digit: 0-9 -> '0'..'9', A-F -> 'A'..'F' ('A' - 10 = 0x37)
  function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
    if (nib < 4'd10) return 8'h30 + {4'h0, nib};
    else             return 8'h37 + {4'h0, nib};
  endfunction

  // Init command sequence, in transmit order
  function automatic logic [7:0] init_cmd(input logic [1:0] idx);
    case (idx)
      2'd0:    return CMD_FUNC;
      2'd1:    return CMD_DISP;
      2'd2:    return CMD_ENTRY;
      default: return CMD_CLEAR;
    endcase
  endfunction

endpackage

// File: rtl/lcd_byte_tx.sv
// One LCD bus write: setup with E low, E pulse, execution wait, done pulse.
module lcd_byte_tx #(
  parameter int T_AS   = 2,
  parameter int T_PW   = 12,
  parameter int T_EXEC = 2000,
  parameter int T_CLR  = 82000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       rs_in,
  input  logic [7:0] byte_in,
  input  logic       long_wait,
  output logic       done,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic [7:0] lcd_db
);

  localparam int T_M1  = (T_CLR > T_EXEC) ? T_CLR : T_EXEC;
  localparam int T_M2  = (T_AS > T_PW) ? T_AS : T_PW;
  localparam int T_MAX = (T_M1 > T_M2) ? T_M1 : T_M2;
  localparam int CW    = $clog2(T_MAX + 1);

  localparam logic [2:0] TX_IDLE  = 3'd0;
  localparam logic [2:0] TX_SETUP = 3'd1;
  localparam logic [2:0] TX_PULSE = 3'd2;
  localparam logic [2:0] TX_WAIT  = 3'd3;
  localparam logic [2:0] TX_DONE  = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          long_q, long_d;
  logic          rs_q, rs_d;
  logic [7:0]    db_q, db_d;

  // Phase sequencing; each phase lasts exactly its count via a down-counter to zero
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    long_d  = long_q;
    rs_d    = rs_q;
    db_d    = db_q;
    case (state_q)
      TX_IDLE: begin
        if (start) begin
          state_d = TX_SETUP;
          cnt_d   = CW'(T_AS - 1);
          rs_d    = rs_in;
          db_d    = byte_in;
          long_d  = long_wait;
        end
      end
      TX_SETUP: begin
        if (cnt_q == '0) begin
          state_d = TX_PULSE;
          cnt_d   = CW'(T_PW - 1);
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      TX_PULSE: begin
        if (cnt_q == '0) begin
          state_d = TX_WAIT;
          cnt_d   = long_q ? CW'(T_CLR - 1) : CW'(T_EXEC - 1);
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      TX_WAIT: begin
        if (cnt_q == '0) state_d = TX_DONE;
        else             cnt_d   = cnt_q - CW'(1);
      end
      default: state_d = TX_IDLE;
    endcase
  end

  // State and bus registers; reset forces E low immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= TX_IDLE;
      cnt_q   <= '0;
      long_q  <= 1'b0;
      rs_q    <= 1'b0;
      db_q    <= 8'h00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      long_q  <= long_d;
      rs_q    <= rs_d;
      db_q    <= db_d;
    end
  end

  assign done   = (state_q == TX_DONE);
  assign lcd_e  = (state_q == TX_PULSE);
  assign lcd_rs = rs_q;
  assign lcd_db = db_q;

endmodule

// File: rtl/lcd_hex_writer.sv
// Writes a 32-bit word as 8 hex characters to line 1 of an HD44780 LCD.
module lcd_hex_writer
  import lcd_pkg::*;
#(
  parameter int T_PWRUP = 750000,
  parameter int T_AS    = 2,
  parameter int T_PW    = 12,
  parameter int T_EXEC  = 2000,
  parameter int T_CLR   = 82000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] DATA,
  input  logic        REFRESH,
  output logic        LCD_E,
  output logic        LCD_RS,
  output logic        LCD_RW,
  output logic [7:0]  LCD_DB,
  output logic        BUSY
);

  localparam int PW_W = $clog2(T_PWRUP + 1);

  logic [2:0]      state_q, state_d;
  logic [PW_W-1:0] pw_cnt_q, pw_cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic            inflight_q, inflight_d;
  logic [31:0]     frame_q, frame_d;
  logic [31:0]     last_q, last_d;
  logic            valid_q, valid_d;

  logic            tx_start, tx_rs, tx_long, tx_done;
  logic [7:0]      tx_byte;
  logic [3:0]      cur_nib;

  // Character index 0 selects the most significant nibble
  assign cur_nib = frame_q[{~idx_q, 2'b00} +: 4];

  // Sequencer: one byte in flight at a time, next byte issued the cycle after done
  always_comb begin
    state_d  = state_q;
    pw_cnt_d = pw_cnt_q;
    idx_d    = idx_q;
    frame_d  = frame_q;
    last_d   = last_q;
    valid_d  = valid_q;
    tx_start = 1'b0;
    tx_rs    = 1'b0;
    tx_byte  = 8'h00;
    tx_long  = 1'b0;
    case (state_q)
      ST_PWRUP: begin
        if (pw_cnt_q == '0) begin
          state_d = ST_INIT;
          idx_d   = 3'd0;
        end else begin
          pw_cnt_d = pw_cnt_q - PW_W'(1);
        end
      end
      ST_INIT: begin
        tx_byte  = init_cmd(idx_q[1:0]);
        tx_long  = (tx_byte == CMD_CLEAR);
        tx_start = !inflight_q;
        if (tx_done) begin
          if (idx_q == 3'd3) state_d = ST_IDLE;
          else               idx_d   = idx_q + 3'd1;
        end
      end
      ST_IDLE: begin
        if (!valid_q || (DATA != last_q) || REFRESH) begin
          frame_d = DATA;
          state_d = ST_ADDR;
        end
      end
      ST_ADDR: begin
        tx_byte  = CMD_LINE1;
        tx_start = !inflight_q;
        if (tx_done) begin
          state_d = ST_CHARS;
          idx_d   = 3'd0;
        end
      end
      ST_CHARS: begin
        tx_rs    = 1'b1;
        tx_byte  = hex_ascii(cur_nib);
        tx_start = !inflight_q;
        if (tx_done) begin
          if (idx_q == 3'd7) begin
            last_d  = frame_q;
            valid_d = 1'b1;
            state_d = ST_IDLE;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      default: state_d = ST_PWRUP;
    endcase
    inflight_d = tx_start | (inflight_q & ~tx_done);
  end

  // Sequencer registers; reset reruns power-up and invalidates the last-written value
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= ST_PWRUP;
      pw_cnt_q   <= PW_W'(T_PWRUP - 1);
      idx_q      <= 3'd0;
      inflight_q <= 1'b0;
      frame_q    <= 32'h0;
      last_q     <= 32'h0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pw_cnt_q   <= pw_cnt_d;
      idx_q      <= idx_d;
      inflight_q <= inflight_d;
      frame_q    <= frame_d;
      last_q     <= last_d;
      valid_q    <= valid_d;
    end
  end

  lcd_byte_tx #(
    .T_AS  (T_AS),
    .T_PW  (T_PW),
    .T_EXEC(T_EXEC),
    .T_CLR (T_CLR)
  ) u_tx (
    .clk      (CLK),
    .rst_n    (RST),
    .start    (tx_start),
    .rs_in    (tx_rs),
    .byte_in  (tx_byte),
    .long_wait(tx_long),
    .done     (tx_done),
    .lcd_e    (LCD_E),
    .lcd_rs   (LCD_RS),
    .lcd_db   (LCD_DB)
  );

  assign LCD_RW = 1'b0;
  assign BUSY   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_lcd_hex_writer.sv
// Directed bench for lcd_hex_writer with shortened timing parameters.
module tb_lcd_hex_writer;

  localparam int T_PWRUP = 20;
  localparam int T_AS    = 2;
  localparam int T_PW    = 4;
  localparam int T_EXEC  = 8;
  localparam int T_CLR   = 30;
  localparam int TMO     = 5000;

  // E-low cycles between strobes (E fall to next E rise)
  localparam int GAP_BYTE  = T_EXEC + T_AS + 2;      // 12
  localparam int GAP_CLEAR = T_CLR + T_AS + 3;       // 35: clear, then IDLE and ADDR issue
  localparam int GAP_RESTART = T_EXEC + T_AS + 3;    // 13: IDLE sees changed DATA
  localparam int LOW_PWRUP = T_PWRUP + T_AS;         // 22 low samples after release

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [31:0] DATA = 32'h0;
  logic        REFRESH = 1'b0;
  logic        LCD_E, LCD_RS, LCD_RW, BUSY;
  logic [7:0]  LCD_DB;

  int errors = 0;
  int checks = 0;

  lcd_hex_writer #(
    .T_PWRUP(T_PWRUP), .T_AS(T_AS), .T_PW(T_PW), .T_EXEC(T_EXEC), .T_CLR(T_CLR)
  ) dut (
    .CLK(CLK), .RST(RST), .DATA(DATA), .REFRESH(REFRESH),
    .LCD_E(LCD_E), .LCD_RS(LCD_RS), .LCD_RW(LCD_RW), .LCD_DB(LCD_DB), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Waits for one E strobe; returns RS/DB seen while E high and E-low count before it
  task automatic get_byte(input int low_init, output logic rs, output logic [7:0] db,
                          output int low);
    int high;
    low = low_init;
    rs  = 1'bx;
    db  = 8'hxx;
    while (1) begin
      @(negedge CLK);
      if (LCD_E === 1'b1) break;
      low++;
      if (low > TMO) begin
        chk("strobe_timeout", {31'h0, LCD_E}, 32'h1);
        return;
      end
    end
    rs   = LCD_RS;
    db   = LCD_DB;
    high = 1;
    while (1) begin
      @(negedge CLK);
      if (LCD_E !== 1'b1) break;
      chk("bus_stable_e_high", {23'h0, LCD_RS, LCD_DB}, {23'h0, rs, db});
      high++;
      if (high > 100) break;
    end
    chk("e_width", high, T_PW);
  endtask

  task automatic expect_byte(input string tag, input int low_init, input logic rs_exp,
                             input logic [7:0] db_exp, input int gap_exp);
    logic       rs;
    logic [7:0] db;
    int         low;
    get_byte(low_init, rs, db, low);
    chk({tag, "_rs"}, {31'h0, rs}, {31'h0, rs_exp});
    chk({tag, "_db"}, {24'h0, db}, {24'h0, db_exp});
    if (gap_exp >= 0) chk({tag, "_gap"}, low, gap_exp);
  endtask

  // act: 0 none, 1 set DATA=act_data, 2 pulse REFRESH; applied after char act_at
  task automatic expect_frame(input logic [63:0] chars, input int first_gap,
                              input int act_at, input int act, input logic [31:0] act_data);
    int li;
    expect_byte("addr", 1, 1'b0, 8'h80, first_gap);
    li = 1;
    for (int i = 0; i < 8; i++) begin
      expect_byte("char", li, 1'b1, chars[63-8*i -: 8], (i == 0) ? GAP_BYTE : ((li == 1) ? GAP_BYTE : GAP_BYTE));
      li = 1;
      if (i == act_at && act == 1) DATA = act_data;
      if (i == act_at && act == 2) begin
        chk("busy_at_refresh", {31'h0, BUSY}, 32'h1);
        REFRESH = 1'b1;
        @(negedge CLK);
        REFRESH = 1'b0;
        li = 2;
      end
    end
  endtask

  task automatic quiet(input int n);
    int cnt = 0;
    repeat (n) begin
      @(negedge CLK);
      if (LCD_E === 1'b1) cnt++;
    end
    chk("quiet_strobes", cnt, 0);
    chk("quiet_busy", {31'h0, BUSY}, 32'h0);
  endtask

  task automatic expect_init(input int first_low);
    expect_byte("init_func",  0, 1'b0, 8'h38, first_low);
    expect_byte("init_disp",  1, 1'b0, 8'h0C, GAP_BYTE);
    expect_byte("init_entry", 1, 1'b0, 8'h06, GAP_BYTE);
    expect_byte("init_clear", 1, 1'b0, 8'h01, GAP_BYTE);
  endtask

  initial begin
    int waited;

    // Reset values
    DATA = 32'h1234ABCD;
    REFRESH = 1'b0;
    RST = 1'b0;
    repeat (5) @(negedge CLK);
    chk("rst_e",    {31'h0, LCD_E},  32'h0);
    chk("rst_rs",   {31'h0, LCD_RS}, 32'h0);
    chk("rst_rw",   {31'h0, LCD_RW}, 32'h0);
    chk("rst_db",   {24'h0, LCD_DB}, 32'h0);
    chk("rst_busy", {31'h0, BUSY},   32'h1);
    RST = 1'b1;

    // Power-up wait, init, first frame, then nothing while DATA is held
    expect_init(LOW_PWRUP);
    expect_frame("1234ABCD", GAP_CLEAR, -1, 0, 32'h0);
    quiet(200);

    // REFRESH in IDLE; DATA changes during the 3rd character
    REFRESH = 1'b1;
    @(negedge CLK);
    REFRESH = 1'b0;
    expect_frame("1234ABCD", -1, 2, 1, 32'h0000000F);
    expect_frame("0000000F", GAP_RESTART, -1, 0, 32'h0);
    quiet(200);

    // REFRESH while busy is dropped
    REFRESH = 1'b1;
    @(negedge CLK);
    REFRESH = 1'b0;
    expect_frame("0000000F", -1, 1, 2, 32'h0);
    quiet(200);

    // REFRESH together with a DATA change gives one frame
    DATA = 32'h1234ABCD;
    REFRESH = 1'b1;
    @(negedge CLK);
    REFRESH = 1'b0;
    expect_frame("1234ABCD", -1, -1, 0, 32'h0);
    quiet(200);

    // Reset while E is high
    DATA = 32'h0000000F;
    waited = 0;
    while (LCD_E !== 1'b1 && waited < TMO) begin
      @(negedge CLK);
      waited++;
    end
    chk("pre_reset_e_high", {31'h0, LCD_E}, 32'h1);
    RST = 1'b0;
    #1;
    chk("mid_rst_e",    {31'h0, LCD_E},  32'h0);
    chk("mid_rst_db",   {24'h0, LCD_DB}, 32'h0);
    chk("mid_rst_busy", {31'h0, BUSY},   32'h1);
    repeat (5) @(negedge CLK);
    RST = 1'b1;
    expect_init(LOW_PWRUP);
    expect_frame("0000000F", GAP_CLEAR, -1, 0, 32'h0);
    quiet(50);
    chk("rw_const", {31'h0, LCD_RW}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
